// File: rtl/display_scanner.sv
// Multiplexed seven-segment scan controller with MSD-first ripple-blank chaining.
// Optional feature: define SCAN_DIMMING_EN to add the brightness[3:0] PWM input.
module display_scanner #(
   parameter int DIGITS = 4,
   parameter int DWELL  = 12000,
   parameter int GUARD  = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [4*DIGITS-1:0]   value,
   input  logic                  load,
   input  logic                  lz_en,
`ifdef SCAN_DIMMING_EN
   input  logic [3:0]            brightness,
`endif
   output logic [3:0]            nibble,
   output logic                  rbi,
   input  logic                  rbo,
   output logic [DIGITS-1:0]     digit_en,
   output logic                  frame_tick
);

   localparam int CW  = $clog2(DWELL);
   localparam int IW  = $clog2(DIGITS);
   localparam int LW  = CW + 1;
   localparam int SUB = DWELL / 16;
   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
   localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
   localparam logic [IW-1:0] IDX_TOP  = IW'(DIGITS - 1);

   logic [4*DIGITS-1:0] shadow_q, shadow_d, display_q, display_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic                rb_chain_q, rb_chain_d;
   logic                lz_latched_q, lz_latched_d;
   logic [3:0]          nibble_q, nibble_d;
   logic                rbi_q, rbi_d;
   logic [DIGITS-1:0]   digit_en_q, digit_en_d;
   logic                frame_tick_q, frame_tick_d;
   logic                frame_start, slot_last, on_phase;
`ifdef SCAN_DIMMING_EN
   logic [3:0]          bright_q, bright_d;
   logic [LW-1:0]       on_lim;
`endif

   // Output registers trail the counter by one cycle, so frame_tick lands on the
   // first cycle after the counter sits at frame start.
   always_comb begin
      frame_start  = (idx_q == IDX_TOP) && (cnt_q == '0);
      slot_last    = (cnt_q == CNT_LAST);
      shadow_d     = load ? value : shadow_q;
      cnt_d        = slot_last ? '0 : cnt_q + CW'(1);
      idx_d        = idx_q;
      if (slot_last)
         idx_d = (idx_q == '0) ? IDX_TOP : idx_q - IW'(1);
      display_d    = frame_start ? shadow_q : display_q;
      lz_latched_d = frame_start ? lz_en : lz_latched_q;
      rb_chain_d   = rb_chain_q;
      if (frame_start)
         rb_chain_d = lz_en;
      else if (slot_last)
         rb_chain_d = rbo & lz_latched_q;
      nibble_d     = nibble_q;
      rbi_d        = rbi_q;
      if (cnt_q == '0) begin
         nibble_d = display_d[4*idx_q +: 4];
         rbi_d    = (idx_q == '0) ? 1'b0 : rb_chain_d;
      end
`ifdef SCAN_DIMMING_EN
      bright_d     = frame_start ? brightness : bright_q;
      on_lim       = LW'((int'(bright_d) + 1) * SUB);
      on_phase     = ({1'b0, cnt_q} < on_lim);
`else
      on_phase     = 1'b1;
`endif
      digit_en_d   = '0;
      if ((cnt_q >= GUARD_C) && on_phase)
         digit_en_d[idx_q] = 1'b1;
      frame_tick_d = frame_start;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         shadow_q     <= '0;
         display_q    <= '0;
         cnt_q        <= '0;
         idx_q        <= IDX_TOP;
         rb_chain_q   <= 1'b0;
         lz_latched_q <= 1'b0;
         nibble_q     <= '0;
         rbi_q        <= 1'b0;
         digit_en_q   <= '0;
         frame_tick_q <= 1'b0;
`ifdef SCAN_DIMMING_EN
         bright_q     <= '0;
`endif
      end else begin
         shadow_q     <= shadow_d;
         display_q    <= display_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         rb_chain_q   <= rb_chain_d;
         lz_latched_q <= lz_latched_d;
         nibble_q     <= nibble_d;
         rbi_q        <= rbi_d;
         digit_en_q   <= digit_en_d;
         frame_tick_q <= frame_tick_d;
`ifdef SCAN_DIMMING_EN
         bright_q     <= bright_d;
`endif
      end
   end

   assign nibble     = nibble_q;
   assign rbi        = rbi_q;
   assign digit_en   = digit_en_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scanner.sv
// Randomized bench for display_scanner: a frame-timeline reference model predicts every output cycle.
module tb_display_scanner;
   localparam int DIGITS = 4;
   localparam int DWELL  = 32;
   localparam int GUARD  = 2;
   localparam int FRAME  = DIGITS * DWELL;

   logic        clk = 1'b0;
   logic        reset_n, load, lz_en, rbo;
   logic [15:0] value;
   logic [3:0]  nibble;
   logic        rbi, frame_tick;
   logic [3:0]  digit_en;
`ifdef SCAN_DIMMING_EN
   logic [3:0]  brightness;
`endif

   int          total = 0;
   int          bad = 0;
   int          kpos = -1;
   bit          mrst = 1'b1;
   bit          chk_on = 1'b0;
   logic [15:0] m_shadow = '0;
   logic [15:0] fval = '0;
   bit          flz = 1'b0;
   int          fbright = 15;

   always #5 clk = ~clk;

   // Behavioural decoder: a zero digit with blanking requested is blanked and passes blanking on.
   assign rbo = rbi & (nibble == 4'h0);

   display_scanner #(.DIGITS(DIGITS), .DWELL(DWELL), .GUARD(GUARD)) dut (
      .clk(clk), .reset_n(reset_n), .value(value), .load(load), .lz_en(lz_en),
`ifdef SCAN_DIMMING_EN
      .brightness(brightness),
`endif
      .nibble(nibble), .rbi(rbi), .rbo(rbo), .digit_en(digit_en), .frame_tick(frame_tick)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at %0t pos=%0d: got %h, expected %h", tag, $time, kpos, got, exp);
      end
   endtask

   // Reference model: position within the frame timeline plus the value/lz latched at frame start.
   always @(posedge clk) begin
      if (!reset_n) begin
         kpos     = -1;
         mrst     = 1'b1;
         m_shadow = '0;
      end else begin
         mrst = 1'b0;
         kpos = (kpos + 1) % FRAME;
         if (kpos == 0) begin
            fval = m_shadow;
            flz  = lz_en;
`ifdef SCAN_DIMMING_EN
            fbright = int'(brightness);
`endif
         end
         if (load) m_shadow = value;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         if (mrst) begin
            chk("rst_en",   32'(digit_en),   32'd0);
            chk("rst_nib",  32'(nibble),     32'd0);
            chk("rst_rbi",  32'(rbi),        32'd0);
            chk("rst_tick", 32'(frame_tick), 32'd0);
         end else begin
            int d, dw;
            logic [31:0] wide, exp_en;
            bit exp_rbi;
            d      = DIGITS - 1 - kpos / DWELL;
            dw     = kpos % DWELL;
            wide   = 32'(fval);
            exp_en = '0;
            if (dw >= GUARD && dw / (DWELL / 16) <= fbright) exp_en[d] = 1'b1;
            exp_rbi = flz && (d > 0) && ((wide >> (4 * (d + 1))) == 0);
            chk("digit_en",   32'(digit_en),   exp_en);
            chk("nibble",     32'(nibble),     (wide >> (4 * d)) & 32'hF);
            chk("rbi",        32'(rbi),        32'(exp_rbi));
            chk("frame_tick", 32'(frame_tick), 32'(kpos == 0));
         end
      end
   end

   task automatic wait_pos(input int p);
      for (int n = 0; n < 2 * FRAME && kpos != p; n++) begin
         @(posedge clk);
         #1;
      end
      if (kpos != p) chk("wait_pos", 32'(kpos), 32'(p));
   endtask

   task automatic do_load(input logic [15:0] v);
      value = v;
      load  = 1'b1;
      @(posedge clk);
      #1;
      load  = 1'b0;
      value = 16'($urandom);
   endtask

   task automatic run_frames(input int n);
      repeat (n * FRAME) @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] rand_val();
      logic [15:0] v;
      for (int i = 0; i < 4; i++)
         v[4*i +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
      return v;
   endfunction

   initial begin
      reset_n = 1'b0; load = 1'b0; lz_en = 1'b0; value = '0;
`ifdef SCAN_DIMMING_EN
      brightness = 4'd15;
`endif
      @(posedge clk); #1;
      chk_on = 1'b1;
      @(posedge clk); #1;
      reset_n = 1'b1;

      lz_en = 1'b0; do_load(16'h1A2F); run_frames(2);
      lz_en = 1'b1; do_load(16'h0040); run_frames(2);
      do_load(16'h0000); run_frames(2);
      do_load(16'h0102); run_frames(2);

      wait_pos(40); do_load(16'hBEEF); run_frames(2);
      wait_pos(FRAME - 1); do_load(16'h1234); run_frames(2);
      wait_pos(10); do_load(16'h5555); do_load(16'h0607); run_frames(2);

      wait_pos(70);
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      run_frames(2);

      for (int it = 0; it < 16; it++) begin
         wait_pos(int'($urandom_range(0, FRAME - 1)));
         lz_en = 1'($urandom_range(0, 1));
`ifdef SCAN_DIMMING_EN
         brightness = 4'($urandom_range(0, 15));
`endif
         do_load(rand_val());
         run_frames(1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
